// File: rtl/flags_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flags_pkg
// Description : Shared definitions for the flags register and save stack:
//               architectural bit positions, default masks, reset value and
//               the privilege-mask helper used to gate IOPL/IF/VM writes.
// Revision    : 1.0 - initial release
// ============================================================================
package flags_pkg;

    localparam int CF_BIT   = 0;
    localparam int PF_BIT   = 2;
    localparam int AF_BIT   = 4;
    localparam int ZF_BIT   = 6;
    localparam int SF_BIT   = 7;
    localparam int TF_BIT   = 8;
    localparam int IF_BIT   = 9;
    localparam int DF_BIT   = 10;
    localparam int OF_BIT   = 11;
    localparam int IOPL_LSB = 12;
    localparam int NT_BIT   = 14;
    localparam int RF_BIT   = 16;
    localparam int VM_BIT   = 17;

    localparam logic [31:0] DEFAULT_WRITABLE_MASK     = 32'h0003_7FD5;
    localparam logic [31:0] DEFAULT_RESERVED_ONE_MASK = 32'h0000_0002;
    localparam logic [31:0] RESET_VALUE               = 32'h0000_0002;

    // Bits cleared in the result may not be changed at this privilege level.
    function automatic logic [31:0] priv_mask(input logic [1:0] cpl,
                                              input logic [1:0] iopl);
        logic [31:0] m;
        m = 32'hFFFF_FFFF;
        if (cpl != 2'd0) begin
            m[IOPL_LSB]   = 1'b0;
            m[IOPL_LSB+1] = 1'b0;
            m[VM_BIT]     = 1'b0;
        end
        if (cpl > iopl) begin
            m[IF_BIT] = 1'b0;
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flags_lifo.sv
`default_nettype none
// ============================================================================
// Module      : flags_lifo
// Description : WIDTH x DEPTH save stack. Push and pop in the same cycle,
//               push when full, and pop when empty are all rejected and
//               raise a one-cycle error pulse.
// Ports       : clock, reset (async, active-high), i_push, i_pop, i_data,
//               o_top (current top entry), o_count, o_full, o_empty, o_error
// Revision    : 1.0 - initial release
// ============================================================================
module flags_lifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_error
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_error;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_error;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~i_pop & ~o_full;
    assign w_pop_ok  = i_pop & ~i_push & ~o_empty;
    assign w_error   = (i_push & i_pop) | (i_push & ~i_pop & o_full) |
                       (i_pop & ~i_push & o_empty);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            r_error <= w_error;
            if (w_push_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop_ok) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage has no reset; contents are meaningless until pushed.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push_ok && (r_count == CW'(i))) begin
                r_mem[i] <= i_data;
            end
        end
    end

    always_comb begin
        o_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_count == CW'(i + 1)) begin
                o_top = r_mem[i];
            end
        end
    end

    assign o_count = r_count;
    assign o_error = r_error;

endmodule
`default_nettype wire

// File: rtl/flags_register_stack.sv
`default_nettype none
// ============================================================================
// Module      : flags_register_stack
// Description : EFLAGS-style flags register with masked, privilege-gated
//               writes, constant reserved bits and a save/restore stack
//               for interrupt entry (push) and IRET/POPF (pop).
// Ports       : clock, reset (async, active-high), write_enable, write_data,
//               write_mask, cpl, push, pop, instr_retire;
//               EFLAGS, FLAGS, decoded flag bits, IOPL, stack_count,
//               stack_full, stack_empty, stack_error
// Options     : FLAGS_RESUME_AUTOCLEAR_EN - RF clears after the first
//               retired instruction once set.
// Revision    : 1.0 - initial release
// ============================================================================
module flags_register_stack
    import flags_pkg::*;
#(
    parameter int          WIDTH             = 32,
    parameter int          STACK_DEPTH       = 4,
    parameter logic [31:0] WRITABLE_MASK     = DEFAULT_WRITABLE_MASK,
    parameter logic [31:0] RESERVED_ONE_MASK = DEFAULT_RESERVED_ONE_MASK
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             write_enable,
    input  logic [WIDTH-1:0]                 write_data,
    input  logic [WIDTH-1:0]                 write_mask,
    input  logic [1:0]                       cpl,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             instr_retire,
    output logic [WIDTH-1:0]                 EFLAGS,
    output logic [15:0]                      FLAGS,
    output logic                             CF,
    output logic                             PF,
    output logic                             AF,
    output logic                             ZF,
    output logic                             SF,
    output logic                             TF,
    output logic                             IF,
    output logic                             DF,
    output logic                             OF,
    output logic                             NT,
    output logic                             RF,
    output logic                             VM,
    output logic [1:0]                       IOPL,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             stack_error
);

    // Masks are trimmed to the configured width so that in 16-bit mode
    // RF, VM and the upper half can never become set.
    localparam logic [31:0] c_WIDTH_MASK = (WIDTH >= 32) ? 32'hFFFF_FFFF :
                                           ((32'd1 << WIDTH) - 32'd1);
    localparam logic [31:0] c_WMASK = WRITABLE_MASK & c_WIDTH_MASK;
    localparam logic [31:0] c_R1    = RESERVED_ONE_MASK & c_WIDTH_MASK;

    logic [WIDTH-1:0] r_flags;
    logic [WIDTH-1:0] w_top;
    logic [31:0]      w_cur;
    logic [31:0]      w_src_data;
    logic [31:0]      w_src_mask;
    logic [31:0]      w_eff;
    logic [31:0]      w_next;
    logic             w_pop_only;

    assign w_cur      = 32'(r_flags);
    assign w_pop_only = pop & ~push;

    always_comb begin
        w_src_data = 32'(write_data);
        w_src_mask = '0;
        if (w_pop_only) begin
            // A pop overrides any write; an empty pop leaves the register alone.
            if (!stack_empty) begin
                w_src_data = 32'(w_top);
                w_src_mask = 32'hFFFF_FFFF;
            end
        end else if (write_enable) begin
            w_src_mask = 32'(write_mask);
        end
        w_eff  = w_src_mask & c_WMASK &
                 priv_mask(cpl, w_cur[IOPL_LSB+1:IOPL_LSB]);
        w_next = (w_cur & ~w_eff) | (w_src_data & w_eff) | c_R1;
`ifdef FLAGS_RESUME_AUTOCLEAR_EN
        // A retire with RF already set clears it, unless this same cycle
        // is (re)loading RF with 1.
        if (instr_retire && w_cur[RF_BIT] && !(w_eff[RF_BIT] && w_src_data[RF_BIT])) begin
            w_next[RF_BIT] = 1'b0;
        end
`endif
    end

`ifndef FLAGS_RESUME_AUTOCLEAR_EN
    logic w_unused_retire;
    assign w_unused_retire = instr_retire;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_flags <= WIDTH'(RESET_VALUE & c_WIDTH_MASK);
        end else begin
            r_flags <= w_next[WIDTH-1:0];
        end
    end

    // The stack captures the pre-write value, so interrupt entry can save
    // the flags and clear IF/TF in one cycle.
    flags_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  (r_flags),
        .o_top   (w_top),
        .o_count (stack_count),
        .o_full  (stack_full),
        .o_empty (stack_empty),
        .o_error (stack_error)
    );

    assign EFLAGS = r_flags;
    assign FLAGS  = w_cur[15:0];
    assign CF     = w_cur[CF_BIT];
    assign PF     = w_cur[PF_BIT];
    assign AF     = w_cur[AF_BIT];
    assign ZF     = w_cur[ZF_BIT];
    assign SF     = w_cur[SF_BIT];
    assign TF     = w_cur[TF_BIT];
    assign IF     = w_cur[IF_BIT];
    assign DF     = w_cur[DF_BIT];
    assign OF     = w_cur[OF_BIT];
    assign NT     = w_cur[NT_BIT];
    assign RF     = w_cur[RF_BIT];
    assign VM     = w_cur[VM_BIT];
    assign IOPL   = w_cur[IOPL_LSB+1:IOPL_LSB];

endmodule
`default_nettype wire

// File: tb/tb_flags_register_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_flags_register_stack
// Description : Self-checking bench for flags_register_stack (default
//               parameters). Expected register/stack state is queued as each
//               cycle is driven and compared once the cycle has completed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flags_register_stack;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        write_enable = 1'b0;
    logic [31:0] write_data = '0;
    logic [31:0] write_mask = '0;
    logic [1:0]  cpl = 2'd0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        instr_retire = 1'b0;
    logic [31:0] EFLAGS;
    logic [15:0] FLAGS;
    logic        CF, PF, AF, ZF, SF, TF, IF, DF, OF, NT, RF, VM;
    logic [1:0]  IOPL;
    logic [2:0]  stack_count;
    logic        stack_full, stack_empty, stack_error;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] d;
        logic [31:0] m;
        logic [1:0]  cpl;
        logic        pu;
        logic        po;
        logic        rt;
        logic [31:0] e;
        logic [2:0]  c;
        logic        er;
    } row_t;

    typedef struct packed {
        logic [31:0] eflags;
        logic [2:0]  count;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    flags_register_stack dut (
        .clock        (clock),
        .reset        (reset),
        .write_enable (write_enable),
        .write_data   (write_data),
        .write_mask   (write_mask),
        .cpl          (cpl),
        .push         (push),
        .pop          (pop),
        .instr_retire (instr_retire),
        .EFLAGS       (EFLAGS),
        .FLAGS        (FLAGS),
        .CF           (CF),
        .PF           (PF),
        .AF           (AF),
        .ZF           (ZF),
        .SF           (SF),
        .TF           (TF),
        .IF           (IF),
        .DF           (DF),
        .OF           (OF),
        .NT           (NT),
        .RF           (RF),
        .VM           (VM),
        .IOPL         (IOPL),
        .stack_count  (stack_count),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .stack_error  (stack_error)
    );

    always #5 clock = ~clock;

    function automatic row_t mk(input logic we, input logic [31:0] d, input logic [31:0] m,
                                input logic [1:0] c_pl, input logic pu, input logic po,
                                input logic rt, input logic [31:0] e, input logic [2:0] c,
                                input logic er);
        row_t r;
        r.we = we; r.d = d; r.m = m; r.cpl = c_pl; r.pu = pu; r.po = po; r.rt = rt;
        r.e = e; r.c = c; r.er = er;
        return r;
    endfunction

    // Drive one cycle of stimulus and queue the state expected after it.
    task automatic step(input row_t r);
        exp_t x;
        write_enable = r.we; write_data = r.d; write_mask = r.m; cpl = r.cpl;
        push = r.pu; pop = r.po; instr_retire = r.rt;
        x.eflags = r.e; x.count = r.c; x.err = r.er;
        exp_q.push_back(x);
        @(posedge clock);
        #1;
        write_enable = 1'b0; write_data = '0; write_mask = '0;
        push = 1'b0; pop = 1'b0; instr_retire = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cpl = 2'd0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (EFLAGS !== 32'h0000_0002 || stack_count !== 3'd0 || stack_error !== 1'b0 ||
            stack_empty !== 1'b1 || stack_full !== 1'b0) begin
            errors++;
            $display("FAIL reset: EFLAGS=%h count=%0d err=%b empty=%b full=%b, expected 00000002 0 0 1 0",
                     EFLAGS, stack_count, stack_error, stack_empty, stack_full);
        end
    endtask

    task automatic test_write_all();
        exp_t x;
        step(mk(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h0003_7FD7, 0, 0));
        x = exp_q.pop_front();
        checks++;
        if (EFLAGS !== x.eflags || stack_count !== x.count || stack_error !== x.err) begin
            errors++;
            $display("FAIL write_all: EFLAGS=%h count=%0d err=%b, expected %h %0d %b",
                     EFLAGS, stack_count, stack_error, x.eflags, x.count, x.err);
        end
        checks++;
        if ({CF, PF, AF, ZF, SF, TF, IF, DF, OF, NT, RF, VM} !== 12'hFFF || IOPL !== 2'd3 ||
            FLAGS !== 16'h7FD7) begin
            errors++;
            $display("FAIL decode: bits=%b IOPL=%0d FLAGS=%h, expected all ones 3 7fd7",
                     {CF, PF, AF, ZF, SF, TF, IF, DF, OF, NT, RF, VM}, IOPL, FLAGS);
        end
        step(mk(1, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h0000_0002, 0, 0));
        x = exp_q.pop_front();
        checks++;
        if (EFLAGS !== x.eflags || {CF, IF, RF, VM} !== 4'b0 || IOPL !== 2'd0) begin
            errors++;
            $display("FAIL write_zero: EFLAGS=%h, expected %h with flags clear", EFLAGS, x.eflags);
        end
    endtask

    task automatic test_privilege();
        row_t t[$];
        exp_t x;
        do_reset();
        t.push_back(mk(1, 32'h0000_3200, 32'h0000_3200, 3, 0, 0, 0, 32'h0000_0002, 0, 0));
        t.push_back(mk(1, 32'h0000_3000, 32'h0000_3000, 0, 0, 0, 0, 32'h0000_3002, 0, 0));
        t.push_back(mk(1, 32'h0000_0200, 32'h0000_0200, 3, 0, 0, 0, 32'h0000_3202, 0, 0));
        t.push_back(mk(1, 32'h0002_0000, 32'h0002_0000, 3, 0, 0, 0, 32'h0000_3202, 0, 0));
        t.push_back(mk(1, 32'hFFFF_FFFF, 32'h0000_000A, 1, 0, 0, 0, 32'h0000_3202, 0, 0));
        t.push_back(mk(1, 32'h0000_0001, 32'h0000_0001, 3, 0, 0, 0, 32'h0000_3203, 0, 0));
        t.push_back(mk(1, 32'h0000_0000, 32'h0000_3000, 2, 0, 0, 0, 32'h0000_3203, 0, 0));
        t.push_back(mk(1, 32'h0000_1000, 32'h0000_3000, 0, 0, 0, 0, 32'h0000_1203, 0, 0));
        t.push_back(mk(1, 32'h0000_0000, 32'h0000_0200, 2, 0, 0, 0, 32'h0000_1203, 0, 0));
        t.push_back(mk(1, 32'h0000_0000, 32'h0000_0200, 1, 0, 0, 0, 32'h0000_1003, 0, 0));
        foreach (t[i]) begin
            step(t[i]);
            x = exp_q.pop_front();
            checks++;
            if (EFLAGS !== x.eflags || stack_count !== x.count || stack_error !== x.err) begin
                errors++;
                $display("FAIL privilege[%0d]: EFLAGS=%h count=%0d err=%b, expected %h %0d %b",
                         i, EFLAGS, stack_count, stack_error, x.eflags, x.count, x.err);
            end
        end
    endtask

    task automatic test_push_pop();
        row_t t[$];
        exp_t x;
        do_reset();
        t.push_back(mk(1, 32'h0000_0202, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'h0000_0202, 0, 0));
        t.push_back(mk(1, 32'h0000_0000, 32'h0000_0300, 0, 1, 0, 0, 32'h0000_0002, 1, 0));
        t.push_back(mk(1, 32'h0000_0001, 32'h0000_0001, 0, 0, 1, 0, 32'h0000_0202, 0, 0));
        // Pop under cpl=3 with IOPL=0: the restored IF is filtered out.
        t.push_back(mk(0, 32'h0, 32'h0, 0, 1, 0, 0, 32'h0000_0202, 1, 0));
        t.push_back(mk(1, 32'h0000_0000, 32'h0000_0200, 0, 0, 0, 0, 32'h0000_0002, 1, 0));
        t.push_back(mk(0, 32'h0, 32'h0, 3, 0, 1, 0, 32'h0000_0002, 0, 0));
        foreach (t[i]) begin
            step(t[i]);
            x = exp_q.pop_front();
            checks++;
            if (EFLAGS !== x.eflags || stack_count !== x.count || stack_error !== x.err) begin
                errors++;
                $display("FAIL push_pop[%0d]: EFLAGS=%h count=%0d err=%b, expected %h %0d %b",
                         i, EFLAGS, stack_count, stack_error, x.eflags, x.count, x.err);
            end
        end
    endtask

    task automatic test_overflow_underflow();
        row_t t[$];
        exp_t x;
        do_reset();
        t.push_back(mk(1, 32'h001, 32'hFD5, 0, 1, 0, 0, 32'h0000_0003, 1, 0));
        t.push_back(mk(1, 32'h004, 32'hFD5, 0, 1, 0, 0, 32'h0000_0006, 2, 0));
        t.push_back(mk(1, 32'h010, 32'hFD5, 0, 1, 0, 0, 32'h0000_0012, 3, 0));
        t.push_back(mk(1, 32'h040, 32'hFD5, 0, 1, 0, 0, 32'h0000_0042, 4, 0));
        t.push_back(mk(1, 32'h080, 32'hFD5, 0, 1, 0, 0, 32'h0000_0082, 4, 1));
        t.push_back(mk(0, 32'h0, 32'h0, 0, 0, 1, 0, 32'h0000_0012, 3, 0));
        t.push_back(mk(0, 32'h0, 32'h0, 0, 0, 1, 0, 32'h0000_0006, 2, 0));
        t.push_back(mk(0, 32'h0, 32'h0, 0, 0, 1, 0, 32'h0000_0003, 1, 0));
        t.push_back(mk(0, 32'h0, 32'h0, 0, 0, 1, 0, 32'h0000_0002, 0, 0));
        t.push_back(mk(1, 32'h1, 32'h1, 0, 0, 1, 0, 32'h0000_0002, 0, 1));
        t.push_back(mk(0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0000_0002, 0, 0));
        foreach (t[i]) begin
            step(t[i]);
            x = exp_q.pop_front();
            checks++;
            if (EFLAGS !== x.eflags || stack_count !== x.count || stack_error !== x.err ||
                stack_full !== (x.count == 3'd4) || stack_empty !== (x.count == 3'd0)) begin
                errors++;
                $display("FAIL overflow[%0d]: EFLAGS=%h count=%0d err=%b full=%b empty=%b, expected %h %0d %b",
                         i, EFLAGS, stack_count, stack_error, stack_full, stack_empty,
                         x.eflags, x.count, x.err);
            end
        end
    endtask

    task automatic test_conflict();
        row_t t[$];
        exp_t x;
        do_reset();
        t.push_back(mk(0, 32'h0, 32'h0, 0, 1, 0, 0, 32'h0000_0002, 1, 0));
        t.push_back(mk(1, 32'h1, 32'h1, 0, 1, 1, 0, 32'h0000_0003, 1, 1));
        t.push_back(mk(0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0000_0003, 1, 0));
        foreach (t[i]) begin
            step(t[i]);
            x = exp_q.pop_front();
            checks++;
            if (EFLAGS !== x.eflags || stack_count !== x.count || stack_error !== x.err) begin
                errors++;
                $display("FAIL conflict[%0d]: EFLAGS=%h count=%0d err=%b, expected %h %0d %b",
                         i, EFLAGS, stack_count, stack_error, x.eflags, x.count, x.err);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t x;
        step(mk(1, 32'h0000_0041, 32'h0000_0041, 0, 1, 0, 0, 32'h0000_0043, 2, 0));
        x = exp_q.pop_front();
        checks++;
        if (EFLAGS !== x.eflags || stack_count !== x.count) begin
            errors++;
            $display("FAIL async_pre: EFLAGS=%h count=%0d, expected %h %0d",
                     EFLAGS, stack_count, x.eflags, x.count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (EFLAGS !== 32'h0000_0002 || stack_count !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: EFLAGS=%h count=%0d, expected 00000002 0",
                     EFLAGS, stack_count);
        end
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_resume_flag();
        row_t t[$];
        exp_t x;
        logic [31:0] after_retire;
`ifdef FLAGS_RESUME_AUTOCLEAR_EN
        after_retire = 32'h0000_0002;
`else
        after_retire = 32'h0001_0002;
`endif
        do_reset();
        t.push_back(mk(1, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, 1, 32'h0001_0002, 0, 0));
        t.push_back(mk(0, 32'h0, 32'h0, 0, 0, 0, 1, after_retire, 0, 0));
        t.push_back(mk(1, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, 0, 32'h0001_0002, 0, 0));
        t.push_back(mk(1, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, 1, 32'h0001_0002, 0, 0));
        t.push_back(mk(0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0001_0002, 0, 0));
        t.push_back(mk(0, 32'h0, 32'h0, 0, 0, 0, 1, after_retire, 0, 0));
        foreach (t[i]) begin
            step(t[i]);
            x = exp_q.pop_front();
            checks++;
            if (EFLAGS !== x.eflags || RF !== x.eflags[16]) begin
                errors++;
                $display("FAIL resume_flag[%0d]: EFLAGS=%h RF=%b, expected %h RF=%b",
                         i, EFLAGS, RF, x.eflags, x.eflags[16]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_all();
        test_privilege();
        test_push_pop();
        test_overflow_underflow();
        test_conflict();
        test_async_reset();
        test_resume_flag();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
